// File: rtl/_skid_buf.sv
// Two-entry skid buffer: registered ready/valid on both sides, one beat per cycle.
// Optional SKID_BUF_STATS_EN adds a saturating 16-bit downstream-stall counter.
package constants;
    localparam int WORD_LENGTH = 32;
endpackage

module _skid_buf #(
    parameter int n = constants::WORD_LENGTH
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [n-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [n-1:0] out_data,
    input  logic         out_ready
`ifdef SKID_BUF_STATS_EN
    ,
    output logic [15:0]  stall_count
`endif
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t       state;
    logic [n-1:0] main;
    logic [n-1:0] skid;
    logic         accept;
    logic         emit;

    // Handshake flags come straight off the state register, so in_ready never sees out_ready.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign out_data  = main;
    assign accept    = in_valid & in_ready;
    assign emit      = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= EMPTY;
            main  <= '0;
            skid  <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: if (accept) begin
                    main  <= in_data;
                    state <= ONE;
                end
                ONE: begin
                    if (accept && emit) begin
                        main <= in_data;
                    end else if (accept) begin
                        skid  <= in_data;
                        state <= FULL;
                    end else if (emit) begin
                        state <= EMPTY;
                    end
                end
                FULL: if (emit) begin
                    main  <= skid;
                    state <= ONE;
                end
                default: state <= EMPTY;
            endcase
        end
    end

`ifdef SKID_BUF_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_count <= '0;
        end else if (out_valid && !out_ready && stall_count != 16'hFFFF) begin
            stall_count <= stall_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb__skid_buf.sv
// Bench for _skid_buf: directed scenarios plus random traffic against a queue model.
module tb__skid_buf;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
`ifdef SKID_BUF_STATS_EN
    logic [15:0] stall_count;
`endif

    int vectors    = 0;
    int miscompares = 0;

    logic [31:0] q[$];
    int unsigned stall_m = 0;

    _skid_buf #(.n(32)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
`ifdef SKID_BUF_STATS_EN
        , .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clock: drive at negedge, compare registered outputs to the model, advance the model.
    task automatic step(input logic v, input logic [31:0] d, input logic r,
                        input logic f, input logic rn);
        logic acc, em;
        in_valid = v; in_data = d; out_ready = r; flush = f; reset_n = rn;
        chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
        chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
        if (q.size() > 0) chk("out_data", out_data, q[0]);
`ifdef SKID_BUF_STATS_EN
        chk("stall_count", {16'd0, stall_count}, stall_m);
`endif
        acc = v && (q.size() < 2);
        em  = r && (q.size() > 0);
        @(posedge clk);
        if (!rn) begin
            q.delete();
            stall_m = 0;
        end else begin
            if (q.size() > 0 && !r && stall_m < 32'hFFFF) stall_m++;
            if (f) q.delete();
            else begin
                if (em) void'(q.pop_front());
                if (acc) q.push_back(d);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        // Reset held with a beat offered; nothing may be captured.
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 32'h1; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("post_rst_out_data", out_data, 32'd0);

        // Streaming A1..A8 with downstream always ready.
        for (int i = 1; i <= 8; i++) step(1'b1, 32'hA0 + i, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);

        // Backpressure into FULL, hold, then drain.
        step(1'b1, 32'hAAAA, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'hBBBB, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'hCCCC, 1'b0, 1'b0, 1'b1);
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        chk("full_hold_data", out_data, 32'hAAAA);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, (i > 0), 1'b0, 1'b1);

        // Flush while FULL with a beat offered.
        step(1'b1, 32'h1111, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h2222, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h3333, 1'b0, 1'b1, 1'b1);
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 2; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);

        // Reset in FULL together with flush and in_valid.
        step(1'b1, 32'h4444, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h5555, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h6666, 1'b0, 1'b1, 1'b0);
        chk("rst_full_out_data", out_data, 32'd0);
        chk("rst_full_out_valid", {31'd0, out_valid}, 32'd0);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 40) == 0), 1'b1);

`ifdef SKID_BUF_STATS_EN
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h7777, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 70000; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("stall_sat", {16'd0, stall_count}, 32'hFFFF);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("stall_after_flush", {16'd0, stall_count}, 32'hFFFF);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("stall_rst", {16'd0, stall_count}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/_skid_buf.md
_SKID_BUF -- requirements
Module: _skid_buf

Interface
REQ-001 SHALL have parameter n, default constants::WORD_LENGTH, giving the data width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset, sampled on rising clk.
REQ-004 SHALL have port flush, input, 1 bit: synchronous discard of all held beats.
REQ-005 SHALL have port in_valid, input, 1 bit: an upstream beat is present (typically the output of a 2-input operand mux).
REQ-006 SHALL have port in_data, input, n bits: the upstream beat.
REQ-007 SHALL have port in_ready, output, 1 bit: the buffer can accept a beat this cycle.
REQ-008 SHALL have port out_valid, output, 1 bit: a downstream beat is present.
REQ-009 SHALL have port out_data, output, n bits: the downstream beat.
REQ-010 SHALL have port out_ready, input, 1 bit: the downstream stage takes the beat this cycle.

Function
REQ-011 SHALL define accept = in_valid & in_ready and emit = out_valid & out_ready, both evaluated in the same cycle.
REQ-012 SHALL hold two n-bit registers, main and skid, and one of three states: EMPTY, ONE (main valid) or FULL (main and skid valid).
REQ-013 SHALL drive in_ready = (state != FULL), decoded only from the state register with no combinational path from out_ready.
REQ-014 SHALL drive out_valid = (state != EMPTY) and out_data = main, both directly from registers.
REQ-015 In EMPTY, on accept SHALL load main <= in_data and go to ONE; otherwise SHALL stay in EMPTY.
REQ-016 In ONE with accept & emit, SHALL load main <= in_data and stay in ONE.
REQ-017 In ONE with accept & !emit, SHALL load skid <= in_data and go to FULL.
REQ-018 In ONE with !accept & emit, SHALL go to EMPTY.
REQ-019 In ONE with neither accept nor emit, SHALL hold.
REQ-020 In FULL, on emit SHALL load main <= skid and go to ONE; otherwise SHALL hold. No accept is possible in FULL.
REQ-021 SHALL preserve beat order with no loss or duplication.
REQ-022 Latency SHALL be 1 cycle from accept into EMPTY to out_valid=1.
REQ-023 Sustained throughput SHALL be one beat per cycle while out_ready=1.
REQ-024 When flush=1, the next state SHALL be EMPTY regardless of accept or emit, and any beat accepted in that cycle SHALL be discarded. in_ready is unaffected by flush in the flush cycle.
REQ-025 main and skid SHALL retain their stale values when not loaded. out_data SHALL be don't-care while out_valid=0, but SHALL remain stable while out_valid=1 and out_ready=0.

Reset
REQ-026 When reset_n=0 at a rising clk, state SHALL be set to EMPTY and main and skid to 0.
REQ-027 Consequently after reset: in_ready=1, out_valid=0, out_data=0.
REQ-028 Reset SHALL take priority over flush, accept and emit, and mid-operation SHALL discard all held beats.

Configuration
REQ-029 With macro SKID_BUF_STATS_EN defined, SHALL add output port stall_count, 16 bits.
REQ-030 stall_count SHALL increment on each cycle with out_valid=1 & out_ready=0, saturate at 16'hFFFF, be cleared to 0 only by reset, and be unaffected by flush.
REQ-031 Without SKID_BUF_STATS_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-032 Reset: hold reset_n=0 with in_valid=1, in_data=32'h1 -> after release in_ready=1, out_valid=0, out_data=0.
REQ-033 Streaming: out_ready=1, send A1..A8 back-to-back -> out_data=A1 one cycle after its accept, then one beat per cycle, in order, in_ready constantly 1.
REQ-034 Backpressure: out_ready=0, send 32'hAAAA then 32'hBBBB -> FULL with in_ready=0 and out_data=32'hAAAA held stable. Raise out_ready -> outputs 32'hAAAA, then 32'hBBBB; in_ready returns to 1 one cycle after the first emit.
REQ-035 Flush in FULL while in_valid=1 -> next cycle out_valid=0, in_ready=1; no flushed beat ever appears at the output.
REQ-036 Reset asserted in FULL together with flush=1 and in_valid=1 -> EMPTY, out_data=0; stall_count=0 if SKID_BUF_STATS_EN.
REQ-037 SKID_BUF_STATS_EN: hold out_valid=1, out_ready=0 for 70000 cycles -> stall_count=16'hFFFF, and it holds across a subsequent flush.
